// File: rtl/baej_branch_pkg.sv
// Shared definitions for the branch resolution unit: opcode encodings,
// FSM state type and the taken-counter ceiling.
package baej_branch_pkg;

    localparam logic [1:0] OP_BEQ = 2'b00;
    localparam logic [1:0] OP_BNE = 2'b01;
    localparam logic [1:0] OP_JMP = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition: equality compare qualified by opcode.
module branch_cond
    import baej_branch_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             cond
);

    logic equal;

    assign equal = (a == b);

    always_comb begin
        cond = 1'b0;
        case (op)
            OP_BEQ:  cond = equal;
            OP_BNE:  cond = !equal;
            OP_JMP:  cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Three-state branch resolver: capture request, evaluate condition and
// redirect target, then hold the result until the fetch stage takes it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. ReqReady and RespValid are decodes of the registered state only;
// RespValid stays high until its handshake unless Flush or Reset intervene.
module branch_resolver
    import baej_branch_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OFF_W = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] PC,
    input  logic [OFF_W-1:0] Offset,
    input  logic             Flush,
    output logic             RespValid,
    input  logic             RespReady,
    output logic             Taken,
    output logic [WIDTH-1:0] NextPC,
    output logic [15:0]      TakenCount,
    output logic [1:0]       DbgState
);

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic             taken_q, taken_d;
    logic [WIDTH-1:0] next_pc_q, next_pc_d;
    logic [15:0]      count_q, count_d;

    logic             cond;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] fallthrough;

    branch_cond #(
        .WIDTH(WIDTH)
    ) u_cond (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .cond(cond)
    );

    // Both adders wrap naturally at WIDTH bits.
    assign target      = pc_q + {{(WIDTH-OFF_W){off_q[OFF_W-1]}}, off_q};
    assign fallthrough = pc_q + WIDTH'(1);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        pc_d      = pc_q;
        off_d     = off_q;
        taken_d   = taken_q;
        next_pc_d = next_pc_q;
        count_d   = count_q;

        if (Flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ReqValid) begin
                        op_d    = Op;
                        a_d     = A;
                        b_d     = B;
                        pc_d    = PC;
                        off_d   = Offset;
                        state_d = ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    taken_d   = cond;
                    next_pc_d = cond ? target : fallthrough;
                    state_d   = ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (RespReady) begin
                        state_d = ST_IDLE;
                        if (taken_q && (count_q != COUNT_MAX)) begin
                            count_d = count_q + 16'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            pc_q      <= '0;
            off_q     <= '0;
            taken_q   <= 1'b0;
            next_pc_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            pc_q      <= pc_d;
            off_q     <= off_d;
            taken_q   <= taken_d;
            next_pc_q <= next_pc_d;
            count_q   <= count_d;
        end
    end

    assign ReqReady   = (state_q == ST_IDLE);
    assign RespValid  = (state_q == ST_ISSUE);
    assign Taken      = taken_q;
    assign NextPC     = next_pc_q;
    assign TakenCount = count_q;
    assign DbgState   = state_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed and randomized bench for branch_resolver with a behavioural
// model of branch outcome, redirect address and saturating taken count.
module tb_branch_resolver;
    import baej_branch_pkg::*;

    localparam int WIDTH = 16;
    localparam int OFF_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a, b, pc;
    logic [OFF_W-1:0] offset;
    logic             flush;
    logic             resp_valid;
    logic             resp_ready;
    logic             taken;
    logic [WIDTH-1:0] next_pc;
    logic [15:0]      taken_count;
    logic [1:0]       dbg_state;

    int checks = 0;
    int errors = 0;
    int model_count = 0;
    logic [16:0] exp_q[$];

    branch_resolver #(
        .WIDTH(WIDTH),
        .OFF_W(OFF_W)
    ) dut (
        .CLK       (clk),
        .Reset     (rst),
        .ReqValid  (req_valid),
        .ReqReady  (req_ready),
        .Op        (op),
        .A         (a),
        .B         (b),
        .PC        (pc),
        .Offset    (offset),
        .Flush     (flush),
        .RespValid (resp_valid),
        .RespReady (resp_ready),
        .Taken     (taken),
        .NextPC    (next_pc),
        .TakenCount(taken_count),
        .DbgState  (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference outcome straight from the branch rules, using integer arithmetic.
    function automatic logic [16:0] ref_branch(input logic [1:0] r_op, input logic [15:0] r_a,
                                               input logic [15:0] r_b, input logic [15:0] r_pc,
                                               input logic [7:0] r_off);
        bit take;
        int soff;
        int dest;
        case (r_op)
            2'd0:    take = (r_a == r_b);
            2'd1:    take = (r_a != r_b);
            2'd2:    take = 1'b1;
            default: take = 1'b0;
        endcase
        soff = (r_off >= 8'd128) ? int'(r_off) - 256 : int'(r_off);
        if (take) dest = (int'(r_pc) + soff) & 32'hFFFF;
        else      dest = (int'(r_pc) + 1) & 32'hFFFF;
        return {take, dest[15:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic [1:0] t_op, input logic [15:0] t_a, input logic [15:0] t_b,
                             input logic [15:0] t_pc, input logic [7:0] t_off);
        req_valid = 1'b1;
        op        = t_op;
        a         = t_a;
        b         = t_b;
        pc        = t_pc;
        offset    = t_off;
    endtask

    task automatic run_branch(input string tag, input logic [1:0] t_op, input logic [15:0] t_a,
                              input logic [15:0] t_b, input logic [15:0] t_pc,
                              input logic [7:0] t_off, input int hold);
        logic [16:0] exp;
        check({tag, " ready_before"}, 32'(req_ready), 32'd1);
        drive_req(t_op, t_a, t_b, t_pc, t_off);
        exp_q.push_back(ref_branch(t_op, t_a, t_b, t_pc, t_off));
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, " eval_state"}, 32'(dbg_state), 32'(ST_EVAL));
        check({tag, " eval_no_valid"}, 32'(resp_valid), 32'd0);
        check({tag, " eval_not_ready"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        exp = exp_q.pop_front();
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, " taken"}, 32'(taken), 32'(exp[16]));
        check({tag, " next_pc"}, 32'(next_pc), 32'(exp[15:0]));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold_valid"}, 32'(resp_valid), 32'd1);
            check({tag, " hold_taken"}, 32'(taken), 32'(exp[16]));
            check({tag, " hold_next_pc"}, 32'(next_pc), 32'(exp[15:0]));
            check({tag, " hold_not_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        if (exp[16] && model_count < 65535) model_count++;
        check({tag, " done_valid"}, 32'(resp_valid), 32'd0);
        check({tag, " done_ready"}, 32'(req_ready), 32'd1);
        check({tag, " count"}, 32'(taken_count), 32'(model_count));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        op         = '0;
        a          = '0;
        b          = '0;
        pc         = '0;
        offset     = '0;
        flush      = 1'b0;
        resp_ready = 1'b0;

        #12;
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset taken", 32'(taken), 32'd0);
        check("reset next_pc", 32'(next_pc), 32'd0);
        check("reset count", 32'(taken_count), 32'd0);
        check("reset req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_branch("beq", OP_BEQ, 16'h1234, 16'h1234, 16'h0040, 8'hF0, 0);
        check("beq directed next_pc", 32'(next_pc), 32'h0030);
        run_branch("bne", OP_BNE, 16'h00FF, 16'h00FF, 16'hFFFF, 8'h10, 0);
        check("bne directed next_pc", 32'(next_pc), 32'h0000);
        run_branch("jmp_hold", OP_JMP, 16'h0000, 16'h0001, 16'hFFF0, 8'h7F, 5);
        check("jmp directed next_pc", 32'(next_pc), 32'h006F);
        run_branch("rsv", OP_RSV, 16'h5555, 16'h5555, 16'h0100, 8'h20, 1);

        // Flush while evaluating.
        drive_req(OP_JMP, 16'h0, 16'h0, 16'h0200, 8'h04);
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_eval state", 32'(dbg_state), 32'(ST_IDLE));
        check("flush_eval ready", 32'(req_ready), 32'd1);
        check("flush_eval valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("flush_eval no_resp", 32'(resp_valid), 32'd0);
        check("flush_eval count", 32'(taken_count), 32'(model_count));

        // Flush in ISSUE coincident with RespReady.
        drive_req(OP_JMP, 16'h0, 16'h0, 16'h0300, 8'h08);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("flush_issue valid_before", 32'(resp_valid), 32'd1);
        flush      = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        flush      = 1'b0;
        resp_ready = 1'b0;
        check("flush_issue ready", 32'(req_ready), 32'd1);
        check("flush_issue valid", 32'(resp_valid), 32'd0);
        check("flush_issue count", 32'(taken_count), 32'(model_count));

        // Flush beats ReqValid in IDLE.
        drive_req(OP_JMP, 16'h0, 16'h0, 16'h0400, 8'h01);
        flush = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_idle state", 32'(dbg_state), 32'(ST_IDLE));
        check("flush_idle ready", 32'(req_ready), 32'd1);

        // Randomized traffic.
        for (int n = 0; n < 30; n++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 1) == 1) ? ra : 16'($urandom);
            run_branch("rand", 2'($urandom_range(0, 3)), ra, rb, 16'($urandom),
                       8'($urandom), $urandom_range(0, 3));
        end

        // Saturation: preload just below the ceiling.
        force dut.count_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.count_q;
        @(negedge clk);
        model_count = 65534;
        check("sat preload", 32'(taken_count), 32'hFFFE);
        run_branch("sat1", OP_JMP, 16'h0, 16'h0, 16'h1000, 8'h02, 0);
        check("sat1 value", 32'(taken_count), 32'hFFFF);
        run_branch("sat2", OP_JMP, 16'h0, 16'h0, 16'h2000, 8'h03, 0);
        check("sat2 value", 32'(taken_count), 32'hFFFF);

        // Asynchronous reset in the middle of EVAL.
        drive_req(OP_JMP, 16'h0, 16'h0, 16'h3000, 8'h05);
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid eval", 32'(dbg_state), 32'(ST_EVAL));
        #2;
        rst = 1'b1;
        #1;
        model_count = 0;
        check("rst_mid valid", 32'(resp_valid), 32'd0);
        check("rst_mid taken", 32'(taken), 32'd0);
        check("rst_mid next_pc", 32'(next_pc), 32'd0);
        check("rst_mid count", 32'(taken_count), 32'(model_count));
        check("rst_mid ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_branch("post_rst", OP_BEQ, 16'h0007, 16'h0007, 16'h0010, 8'h80, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
